// File: rtl/core_defs.sv
// Shared encodings for the EX-stage HI/LO multiply path.
package core_defs;

  typedef enum logic [2:0] {
    HILO_NONE  = 3'd0,
    HILO_MULT  = 3'd1,
    HILO_MULTU = 3'd2,
    HILO_MTHI  = 3'd3,
    HILO_MTLO  = 3'd4
  } hilo_op_t;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Earliest wcnt value at which the controller's completion is trusted.
  localparam logic [1:0] MUL_MIN_LAT = 2'd2;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU);
  endfunction

endpackage

// File: rtl/mult_issue_hilo.sv
// Multiplier requester for EX: issues MULT/MULTU, stalls until the product returns,
// owns the architectural HI/LO registers and drains flushed multiplies silently.
module mult_issue_hilo
  import core_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  input  logic        ex_flush,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_start,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_busy,
  input  logic [63:0] mul_p,
  input  logic        mul_over
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sign_q, sign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic ex_is_mul;
  logic issue;
  logic accept;
  logic move_ok;
  logic [1:0] wcnt_inc;

  always_comb begin
    ex_is_mul = ex_valid & is_mul_op(ex_op);
    issue     = (state_q == StIdle) & ex_is_mul & ~ex_flush;
    // An over seen before MUL_MIN_LAT belongs to a previous, already-rewound operation.
    accept    = (state_q != StIdle) & mul_over & (wcnt_q >= MUL_MIN_LAT);
    wcnt_inc  = (wcnt_q == 2'd3) ? 2'd3 : wcnt_q + 2'd1;
  end

  always_comb begin
    mul_start = 1'b0;
    mul_sign  = sign_q;
    mul_a     = op_a_q;
    mul_b     = op_b_q;
    mul_busy  = 1'b0;
    stall_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        mul_start = issue;
        mul_sign  = (ex_op == HILO_MULT);
        mul_a     = ex_rs_data;
        mul_b     = ex_rt_data;
        stall_req = issue;
      end
      StWait: begin
        mul_start = 1'b1;
        mul_busy  = accept;
        stall_req = ~accept;
      end
      StDrain: begin
        mul_start = 1'b1;
        mul_busy  = accept;
        // Only a new multiply must wait; moves can retire around the drain.
        stall_req = ex_is_mul;
      end
      default: ;
    endcase
  end

  always_comb begin
    move_ok = ex_valid & ~ex_flush & ~stall_req & (state_q != StWait);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          op_a_d  = ex_rs_data;
          op_b_d  = ex_rt_data;
          sign_d  = (ex_op == HILO_MULT);
          wcnt_d  = 2'd1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (accept) begin
          if (!ex_flush) begin
            hi_d = mul_p[63:32];
            lo_d = mul_p[31:0];
          end
          wcnt_d  = 2'd0;
          state_d = StIdle;
        end else begin
          wcnt_d = wcnt_inc;
          if (ex_flush) state_d = StDrain;
        end
      end
      StDrain: begin
        if (accept) begin
          wcnt_d  = 2'd0;
          state_d = StIdle;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    if (move_ok && ex_op == HILO_MTHI) hi_d = ex_rs_data;
    if (move_ok && ex_op == HILO_MTLO) lo_d = ex_rs_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wcnt_q  <= 2'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      sign_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mult_issue_hilo.sv
// Directed bench for mult_issue_hilo with a small behavioural multiplier controller.
module tb_mult_issue_hilo;
  import core_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic        ex_flush;
  logic        stall_req;
  logic [31:0] hi_o, lo_o;
  logic        mul_start, mul_sign, mul_busy, mul_over;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;

  int n_tests = 0;
  int n_fail  = 0;

  // Controller model: over on the third consecutive start cycle, rewound by busy.
  logic [1:0] mcnt;
  logic       stale;

  always_ff @(posedge clk) begin
    if (rst || mul_busy) mcnt <= 2'd0;
    else if (mul_start && mcnt != 2'd3) mcnt <= mcnt + 2'd1;
  end

  always_comb begin
    mul_over = (mcnt >= 2'd2) | stale;
    if (mul_sign) mul_p = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    else          mul_p = {32'd0, mul_a} * {32'd0, mul_b};
  end

  mult_issue_hilo dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_flush   (ex_flush),
    .stall_req  (stall_req),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .mul_start  (mul_start),
    .mul_sign   (mul_sign),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_busy   (mul_busy),
    .mul_p      (mul_p),
    .mul_over   (mul_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from the issue cycle; leaves the bench at T+3 with inputs idle.
  task automatic do_mul(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic inj_stale);
    logic exp_sign;
    exp_sign   = (op == HILO_MULT);
    ex_valid   = 1'b1;
    ex_op      = op;
    ex_rs_data = a;
    ex_rt_data = b;
    ex_flush   = 1'b0;
    stale      = inj_stale;
    @(negedge clk);
    check({tag, " T start"}, 64'(mul_start), 64'd1);
    check({tag, " T stall"}, 64'(stall_req), 64'd1);
    check({tag, " T busy"},  64'(mul_busy),  64'd0);
    check({tag, " T sign"},  64'(mul_sign),  64'(exp_sign));
    check({tag, " T a"},     64'(mul_a),     64'(a));
    next_cycle();
    @(negedge clk);
    check({tag, " T1 start"}, 64'(mul_start), 64'd1);
    check({tag, " T1 stall"}, 64'(stall_req), 64'd1);
    check({tag, " T1 busy"},  64'(mul_busy),  64'd0);
    check({tag, " T1 sign"},  64'(mul_sign),  64'(exp_sign));
    next_cycle();
    stale = 1'b0;
    @(negedge clk);
    check({tag, " T2 start"}, 64'(mul_start), 64'd1);
    check({tag, " T2 stall"}, 64'(stall_req), 64'd0);
    check({tag, " T2 busy"},  64'(mul_busy),  64'd1);
    check({tag, " T2 b"},     64'(mul_b),     64'(b));
    next_cycle();
    ex_valid = 1'b0;
    ex_op    = HILO_NONE;
    check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    ex_valid   = 1'b0;
    ex_op      = HILO_NONE;
    ex_rs_data = 32'd0;
    ex_rt_data = 32'd0;
    ex_flush   = 1'b0;
    stale      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst hi",    64'(hi_o),      64'd0);
    check("rst lo",    64'(lo_o),      64'd0);
    check("rst start", 64'(mul_start), 64'd0);
    check("rst busy",  64'(mul_busy),  64'd0);
    check("rst stall", 64'(stall_req), 64'd0);
    next_cycle();

    do_mul("mult", HILO_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_mul("multu", HILO_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

    // Back-to-back, with a stale over presented early on the 2nd and 3rd.
    do_mul("b2b1", HILO_MULT, 32'd3,         32'd4,         32'h0000_0000, 32'h0000_000C, 1'b0);
    do_mul("b2b2", HILO_MULT, 32'hFFFF_FFFB, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b1);
    do_mul("b2b3", HILO_MULT, 32'd7,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFC8, 1'b1);

    // MTHI, then a multiply flushed at T+1 drains while MTLO retires.
    ex_valid   = 1'b1;
    ex_op      = HILO_MTHI;
    ex_rs_data = 32'h1234_5678;
    @(negedge clk);
    check("mthi stall", 64'(stall_req), 64'd0);
    next_cycle();
    check("mthi hi", 64'(hi_o), 64'h1234_5678);
    ex_op      = HILO_MULT;
    ex_rs_data = 32'd3;
    ex_rt_data = 32'd5;
    @(negedge clk);
    check("drain T start", 64'(mul_start), 64'd1);
    next_cycle();
    ex_flush = 1'b1;
    @(negedge clk);
    check("drain T1 stall", 64'(stall_req), 64'd1);
    check("drain T1 busy",  64'(mul_busy),  64'd0);
    next_cycle();
    ex_flush   = 1'b0;
    ex_op      = HILO_MTLO;
    ex_rs_data = 32'h0000_ABCD;
    @(negedge clk);
    check("drain busy",  64'(mul_busy),  64'd1);
    check("drain start", 64'(mul_start), 64'd1);
    check("drain stall", 64'(stall_req), 64'd0);
    next_cycle();
    ex_valid = 1'b0;
    ex_op    = HILO_NONE;
    check("drain hi", 64'(hi_o), 64'h1234_5678);
    check("drain lo", 64'(lo_o), 64'h0000_ABCD);
    @(negedge clk);
    check("drain idle start", 64'(mul_start), 64'd0);
    next_cycle();

    // Flush in the issue cycle.
    ex_valid   = 1'b1;
    ex_op      = HILO_MULT;
    ex_rs_data = 32'd9;
    ex_rt_data = 32'd9;
    ex_flush   = 1'b1;
    @(negedge clk);
    check("fl0 start", 64'(mul_start), 64'd0);
    check("fl0 stall", 64'(stall_req), 64'd0);
    next_cycle();
    ex_valid = 1'b0;
    ex_flush = 1'b0;
    @(negedge clk);
    check("fl1 start", 64'(mul_start), 64'd0);
    next_cycle();
    @(negedge clk);
    check("fl2 start", 64'(mul_start), 64'd0);
    check("fl2 hi",    64'(hi_o),      64'h1234_5678);
    next_cycle();

    // Reset at T+1 of a multiply.
    ex_valid   = 1'b1;
    ex_op      = HILO_MULT;
    ex_rs_data = 32'd9;
    ex_rt_data = 32'd9;
    next_cycle();
    rst      = 1'b1;
    ex_valid = 1'b0;
    ex_op    = HILO_NONE;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mrst start", 64'(mul_start), 64'd0);
    check("mrst busy",  64'(mul_busy),  64'd0);
    check("mrst stall", 64'(stall_req), 64'd0);
    check("mrst hi",    64'(hi_o),      64'd0);
    check("mrst lo",    64'(lo_o),      64'd0);
    next_cycle();
    do_mul("post rst", HILO_MULT, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_issue_hilo.md
# mult_issue_hilo

Requester side of the multiplier handshake in the EX stage. Accepts MULT/MULTU/MTHI/MTLO from EX, drives start/sign/operands into `mult_controller`, stalls the pipeline until the product returns, and commits it into the architectural HI/LO registers. It also completes a flushed multiply's handshake silently, so the multiplier always returns to a clean state.

## Interface
Parameters: none (encodings in shared package).
- `clk`  in  1  core clock
- `rst`  in  1  reset; one clock; synchronous, active-high
- `ex_valid`  in  1  EX holds a valid instruction
- `ex_op`  in  3  `HILO_NONE/MULT/MULTU/MTHI/MTLO` (package encoding)
- `ex_rs_data`  in  32  rs operand (multiplicand; MTHI/MTLO source)
- `ex_rt_data`  in  32  rt operand (multiplier)
- `ex_flush`  in  1  kill the EX instruction (exception/eret)
- `stall_req`  out  1  hold IF..EX this cycle
- `hi_o`, `lo_o`  out  32 each  architectural HI/LO (registered)
- `mul_start`  out  1  to controller `start`
- `mul_sign`  out  1  to controller `sign` (1 = MULT)
- `mul_a`, `mul_b`  out  32 each  to controller `A`/`B`
- `mul_busy`  out  1  to controller `is_busbusy`; 1 = result taken, rewind counter
- `mul_p`  in  64  from controller `P`
- `mul_over`  in  1  from controller `opreat_over`

## Operation
- FSM states: IDLE, WAIT, DRAIN; 2-bit wait counter `wcnt`.
- Issue: in IDLE, `ex_valid & ~ex_flush & op∈{MULT,MULTU}`.
  - Latch rs/rt/sign into operand regs.
  - Set `wcnt=1`; go to WAIT.
- `mul_start`: combinational.
  - In the issue cycle (IDLE): operands come from `ex_*` directly.
  - In WAIT and DRAIN: operands come from the latched regs, held stable.
  - Otherwise 0.
- Result capture: `mul_over` is accepted only when `wcnt≥2`. `mul_over` earlier than that is stale and ignored.
- WAIT, accepted over:
  - `mul_busy=1` with `mul_start=1` in that cycle.
  - HI←P[63:32], LO←P[31:0] at the clock edge.
  - Go to IDLE.
- WAIT, not accepted: `wcnt` increments, saturating at 3; no timeout.
- DRAIN: identical handshake, but P is discarded and HI/LO are untouched.
- `stall_req`:
  - 1 in the issue cycle and in WAIT until the accept cycle, where it is 0 so the instruction retires at that edge.
  - 1 in DRAIN only if EX presents a MULT/MULTU; MTHI/MTLO are not stalled.
- Flush:
  - In the issue cycle: no issue; stay IDLE.
  - During WAIT: go to DRAIN, or straight to IDLE if the over is accepted that same cycle; in that case the result is discarded and HI/LO are not written.
- MTHI/MTLO:
  - Write `ex_rs_data` at the edge when `ex_valid & ~ex_flush & ~stall_req`.
  - Allowed in IDLE and DRAIN.
  - A DRAIN discard never overwrites them.
- `mul_busy=0` and `mul_start=0` in every cycle not listed above.

## Timing
- Reset (synchronous):
  - state=IDLE, `wcnt`=0, operand regs=0.
  - `hi_o`=`lo_o`=0.
  - `mul_start`/`mul_busy`/`stall_req`=0 from the following cycle.
  - Reset mid-WAIT/DRAIN aborts with no HI/LO write; the controller shares `rst`.
- MULT/MULTU issued in cycle T:
  - T: start=1, stall=1.
  - T+1: start=1, stall=1, over=0.
  - T+2: over=1 → busy=1, stall=0.
  - HI/LO are visible at T+3.
  - Total: 3 EX cycles.
- Back-to-back multiplies: the second issues at T+3. Start is low for ≥0 cycles between them; the controller counter is already rewound by `mul_busy`.
- MTHI/MTLO: single cycle; visible next cycle.
- MFHI/MFLO: no forwarding here. The consumer reads `hi_o`/`lo_o`; the ID-side hazard unit owns ordering.

## Structure
- Shared package `core_defs`:
  - `hilo_op_t` encodings: NONE=0, MULT=1, MULTU=2, MTHI=3, MTLO=4.
  - FSM state constants.
  - `MUL_MIN_LAT=2`, the `wcnt` threshold.
- Single module, no sub-module. The multiplier stays in `mult_controller`, instantiated by the EX top beside this block.

## Test plan
- MULT 0xFFFFFFFF×0x00000002 → stall_req high for 2 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+3; `mul_busy` pulses once at T+2.
- MULTU 0xFFFFFFFF×0x00000002 → HI=0x00000001, LO=0xFFFFFFFE; `mul_sign`=0 throughout.
- Three consecutive MULTs (3×4, −5×6, 7×−8) → results 12, −30, −56, each taking 3 EX cycles; no stale `mul_over` is accepted at the start of the 2nd or 3rd.
- MTHI 0x12345678, then MULT flushed at T+1 → DRAIN completes the handshake and HI stays 0x12345678. A following MTLO 0xABCD is accepted during DRAIN without stall.
- Flush in the issue cycle → `mul_start` never rises after that cycle; state stays IDLE.
- `rst` asserted at T+1 of a MULT → next cycle all outputs 0, HI/LO=0. A new MULT 2×3 then yields LO=6, HI=0 with nominal latency.
